// File: rtl/data_mem_io.sv
// Data-side memory block: word-addressed RAM plus a small memory-mapped
// register window holding a compare/interrupt timer and a GPIO output.
module data_mem_io #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] IO_BASE     = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic [31:0] MA,
    input  logic [31:0] MWD,
    input  logic        MWR,
    input  logic        MOE,
    output logic [31:0] MRD,
    output logic        IRQ,
    output logic [31:0] GPIO_OUT
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

    localparam logic [2:0] OFF_CNT  = 3'd0;
    localparam logic [2:0] OFF_CMP  = 3'd1;
    localparam logic [2:0] OFF_CTRL = 3'd2;
    localparam logic [2:0] OFF_STAT = 3'd3;
    localparam logic [2:0] OFF_GPIO = 3'd4;

    logic [31:0] r_ram [DEPTH_WORDS];
    logic [31:0] r_cnt;
    logic [31:0] r_cmp;
    logic [2:0]  r_ctrl;
    logic        r_pend;
    logic [31:0] r_gpio;
    logic        r_irq;

    logic          w_ram_sel;
    logic          w_io_sel;
    logic [2:0]    w_off;
    logic [AW-1:0] w_ram_addr;
    logic [31:0]   w_ram_rdata;
    logic          w_io_wr;
    logic          w_match;
    logic [31:0]   w_cnt_nxt;
    logic [31:0]   w_cmp_nxt;
    logic [2:0]    w_ctrl_nxt;
    logic          w_pend_nxt;
    logic [31:0]   w_gpio_nxt;
    logic [31:0]   w_rd;

    assign w_ram_sel  = (MA < RAM_BYTES);
    assign w_io_sel   = (MA[31:5] == IO_BASE[31:5]);
    assign w_off      = MA[4:2];
    assign w_ram_addr = MA[AW+1:2];
    assign w_io_wr    = MWR && w_io_sel;

    // RAM contents survive reset; the read port sees the pre-write word.
    always_ff @(posedge clk) begin
        if (MWR && w_ram_sel) begin
            r_ram[w_ram_addr] <= MWD;
        end
    end

    assign w_ram_rdata = r_ram[w_ram_addr];

    // Compare uses the current (pre-write) CNT and the CMP already in effect.
    assign w_match = r_ctrl[0] && (r_cnt == r_cmp);

    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_cmp_nxt  = r_cmp;
        w_ctrl_nxt = r_ctrl;
        w_pend_nxt = r_pend;
        w_gpio_nxt = r_gpio;

        if (w_io_wr && (w_off == OFF_CNT)) begin
            w_cnt_nxt = MWD;
        end else if (r_ctrl[0]) begin
            w_cnt_nxt = (w_match && r_ctrl[2]) ? 32'd0 : r_cnt + 32'd1;
        end

        if (w_io_wr && (w_off == OFF_CMP)) begin
            w_cmp_nxt = MWD;
        end
        if (w_io_wr && (w_off == OFF_CTRL)) begin
            w_ctrl_nxt = MWD[2:0];
        end
        if (w_io_wr && (w_off == OFF_GPIO)) begin
            w_gpio_nxt = MWD;
        end

        // A new match beats a simultaneous write-one-to-clear.
        if (w_match) begin
            w_pend_nxt = 1'b1;
        end else if (w_io_wr && (w_off == OFF_STAT) && MWD[0]) begin
            w_pend_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_cnt  <= 32'd0;
            r_cmp  <= 32'hFFFF_FFFF;
            r_ctrl <= 3'd0;
            r_pend <= 1'b0;
            r_gpio <= 32'd0;
            r_irq  <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_cmp  <= w_cmp_nxt;
            r_ctrl <= w_ctrl_nxt;
            r_pend <= w_pend_nxt;
            r_gpio <= w_gpio_nxt;
            r_irq  <= w_pend_nxt & w_ctrl_nxt[1];
        end
    end

    always_comb begin
        w_rd = 32'd0;
        if (MOE) begin
            if (w_ram_sel) begin
                w_rd = w_ram_rdata;
            end else if (w_io_sel) begin
                case (w_off)
                    OFF_CNT:  w_rd = r_cnt;
                    OFF_CMP:  w_rd = r_cmp;
                    OFF_CTRL: w_rd = {29'd0, r_ctrl};
                    OFF_STAT: w_rd = {31'd0, r_pend};
                    OFF_GPIO: w_rd = r_gpio;
                    default:  w_rd = 32'd0;
                endcase
            end
        end
    end

    assign MRD      = w_rd;
    assign IRQ      = r_irq;
    assign GPIO_OUT = r_gpio;

endmodule

// File: doc/data_mem_io.md
DATA_MEM_IO -- requirements
Module: data_mem_io

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, giving the data RAM size in 32-bit words (power of two, at least 16).
REQ-002 The block SHALL have parameter IO_BASE, default 32'hFFFF_0000, giving the base of the memory-mapped register window.
REQ-003 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port RESET  input  1  synchronous, active-high reset.
REQ-005 Port MA  input  32  byte address from the MEM stage; bits [1:0] are ignored.
REQ-006 Port MWD  input  32  write data.
REQ-007 Port MWR  input  1  write strobe; the write commits on the clock edge.
REQ-008 Port MOE  input  1  read enable.
REQ-009 Port MRD  output  32  read data, combinational from MA in the same cycle.
REQ-010 Port IRQ  output  1  timer interrupt request to the CPU.
REQ-011 Port GPIO_OUT  output  32  general-purpose output register.

Function
REQ-012 The block SHALL decode the RAM region as MA < DEPTH_WORDS*4, indexed by word MA[log2(DEPTH_WORDS)+1:2].
REQ-013 The block SHALL decode the IO region as MA[31:5] == IO_BASE[31:5], with registers selected by MA[4:2]: 0 CNT, 1 CMP, 2 CTRL, 3 STAT, 4 GPIO.
REQ-014 MRD SHALL be 0 when MOE=0, when MA is unmapped, or when MA selects an undefined IO offset (5-7).
REQ-015 A RAM write SHALL commit when MWR=1 and the address is in the RAM region; a read of the same word in the same cycle SHALL return the old value.
REQ-016 Writes to unmapped addresses or undefined IO offsets SHALL be ignored.
REQ-017 CTRL SHALL be 3 bits, read back zero-extended: bit0 EN (count), bit1 IE (interrupt enable), bit2 AR (auto-reload).
REQ-018 When EN=1 and no CNT write occurs, CNT SHALL increment by 1 per cycle, wrapping from 32'hFFFF_FFFF to 0.
REQ-019 When EN=1 and CNT==CMP, the block SHALL set STAT.PEND on the next edge.
REQ-020 On that same edge, if AR=1, CNT SHALL load 0 instead of incrementing.
REQ-021 A CPU write to CNT SHALL override the increment and the auto-reload on that edge.
REQ-022 A compare match SHALL be evaluated on the pre-write CNT value.
REQ-023 A write to CMP SHALL affect compares from the next cycle onward.
REQ-024 A STAT write with MWD[0]=1 SHALL clear PEND; MWD[0]=0 SHALL leave PEND unchanged.
REQ-025 If a compare match and a PEND clear occur on the same edge, the set SHALL win.
REQ-026 STAT SHALL read as {31'b0, PEND}.
REQ-027 IRQ SHALL be registered: IRQ = PEND & IE, reflecting state after each edge (no combinational path from MA/MWD).
REQ-028 When EN=0, CNT SHALL hold its value and no new PEND SHALL be set; an existing PEND SHALL remain until cleared.
REQ-029 GPIO_OUT SHALL equal the GPIO register, which updates on writes and reads back its value.

Reset
REQ-030 While RESET=1, the block SHALL force CNT=0, CMP=32'hFFFF_FFFF, CTRL=0, PEND=0, GPIO=0 and IRQ=0.
REQ-031 RESET SHALL take priority over any simultaneous write or compare.
REQ-032 RAM contents SHALL NOT be reset.
REQ-033 Reset asserted mid-count SHALL leave the timer stopped, with IRQ low on the first edge after RESET deasserts.

Verification
REQ-034 Write 32'hDEAD_BEEF to 0x0000_0010, then read 0x0000_0010 and 0x0000_0013 -> both return 32'hDEAD_BEEF; a read of 0x0000_1000 returns 0.
REQ-035 CMP=5, CTRL=3'b011, CNT=0 -> CNT counts 0..5; PEND and IRQ go high on the edge after CNT==5; CNT continues to 6 (AR=0).
REQ-036 CMP=3, CTRL=3'b111 -> CNT sequence 0,1,2,3,0,1,...; IRQ stays high until STAT is written with 1, then falls on the next edge.
REQ-037 W1C to STAT on the same edge as a new match -> PEND remains 1.
REQ-038 Write CNT=100 on the same edge as a match with AR=1 -> CNT=100 and PEND=1.
REQ-039 Assert RESET for 1 cycle while CNT=7 and IRQ=1 -> all registers return to reset values and IRQ=0; GPIO written with 32'h0000_00A5 before reset reads 0 after reset.
